// File: rtl/router_sync_param.sv
// rtl/router_sync_param.sv - address latch, one-hot write decode, full mux, valid and timeout soft resets for N FIFOs
module router_sync_param #(
    parameter int N       = 3,
    parameter int AW      = 2,
    parameter int TIMEOUT = 30,
    parameter int SRST_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          detect_add,
    input  logic [AW-1:0] addr_in,
    input  logic          write_enb_reg,
    input  logic [N-1:0]  read_enb,
    input  logic [N-1:0]  empty,
    input  logic [N-1:0]  full,
    output logic [N-1:0]  write_enb,
    output logic [N-1:0]  vld_out,
    output logic          fifo_full,
    output logic [N-1:0]  soft_rst,
    output logic          addr_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0] N_W = (AW+1)'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    if ((2 ** AW) < N || TIMEOUT < 2 || N < 1 || N > 16) begin : g_bad_params
        $fatal(1, "router_sync_param: illegal N/AW/TIMEOUT combination");
    end

    logic [AW-1:0] addr_reg;
    logic          addr_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
            addr_vld <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (detect_add) begin
                addr_reg <= addr_in;
                addr_vld <= ({1'b0, addr_in} < N_W);
                addr_err <= ({1'b0, addr_in} >= N_W);
            end
        end
    end

    // Decode and full mux share the old addr_reg, so a same-cycle header does not redirect the write.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (addr_vld && (addr_reg == AW'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    for (genvar g = 0; g < N; g++) begin : g_chan
        if (SRST_EN != 0) begin : g_srst
            logic [CW-1:0] cnt;
            logic          stall;

            assign stall = vld_out[g] & ~read_enb[g];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt         <= '0;
                    soft_rst[g] <= 1'b0;
                end else if (!stall) begin
                    cnt         <= '0;
                    soft_rst[g] <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    cnt         <= '0;
                    soft_rst[g] <= 1'b1;
                end else begin
                    cnt         <= cnt + CW'(1);
                    soft_rst[g] <= 1'b0;
                end
            end
        end else begin : g_no_srst
            assign soft_rst[g] = 1'b0;
        end
    end

endmodule
